exu_ctrl: RTL

Execution-unit controller that sequences one instruction at a time through FETCH, EXEC, MEM and WB. It requests instructions from the fetch unit and latches the one-hot decode, register selects and immediate from the instruction decode unit. It then drives ALU op-select, register-file write and memory handshakes, and maintains the compare flag and a retired-instruction counter. It sits between the instruction decode unit and the execution datapath, register file and data memory.

---
 rtl/exu_ctrl_if.sv | 53 +++++
 rtl/exu_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/exu_ctrl_if.sv
// Control bundle between exu_ctrl and the IDU, ALU, register file and data memory.
// master is the controller side; slave is the surrounding datapath side.
interface exu_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             if_req_o;
  logic             if_ack_i;
  logic [11:0]      id_op_i;
  logic             src_reg_i;
  logic             dst_reg_i;
  logic [7:0]       imm_addr_const_i;
  logic [2:0]       alu_op_o;
  logic             alu_imm_o;
  logic             alu_cmp_i;
  logic             rf_src_o;
  logic             rf_dst_o;
  logic             rf_we_o;
  logic             rf_wsel_mem_o;
  logic             mem_req_o;
  logic             mem_we_o;
  logic [7:0]       mem_addr_o;
  logic             mem_ack_i;
  logic             cmp_flag_o;
  logic             busy_o;
  logic [1:0]       err_o;
  logic [CNT_W-1:0] retired_o;

  modport master (
    output if_req_o,
    input  if_ack_i, id_op_i, src_reg_i,
    input  dst_reg_i, imm_addr_const_i,
    output alu_op_o, alu_imm_o,
    input  alu_cmp_i,
    output rf_src_o, rf_dst_o, rf_we_o,
    output rf_wsel_mem_o,
    output mem_req_o, mem_we_o, mem_addr_o,
    input  mem_ack_i,
    output cmp_flag_o, busy_o, err_o, retired_o
  );

  modport slave (
    input  if_req_o,
    output if_ack_i, id_op_i, src_reg_i,
    output dst_reg_i, imm_addr_const_i,
    input  alu_op_o, alu_imm_o,
    output alu_cmp_i,
    input  rf_src_o, rf_dst_o, rf_we_o,
    input  rf_wsel_mem_o,
    input  mem_req_o, mem_we_o, mem_addr_o,
    output mem_ack_i,
    input  cmp_flag_o, busy_o, err_o, retired_o
  );
endinterface

// File: rtl/exu_ctrl.sv
// Execution-unit sequencer: FETCH -> EXEC -> (MEM) -> WB, one instruction at a time.
// Tracks compare flag, retired count and sticky decode / memory-timeout errors.
module exu_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input logic        clock,
  input logic        reset,
  exu_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, FETCH, EXEC, MEM, WB, ERR
  } state_t;

  localparam int OP_LD     = 11;
  localparam int OP_AND    = 10;
  localparam int OP_STR    = 9;
  localparam int OP_ADD    = 8;
  localparam int OP_ADDI   = 7;
  localparam int OP_CMPLT  = 6;
  localparam int OP_CMPEQ  = 5;
  localparam int OP_CMPEQI = 4;
  localparam int OP_SHFTR  = 3;
  localparam int OP_SHFTL  = 2;
  localparam int OP_INV    = 1;
  localparam int OP_MVI    = 0;

  localparam logic [11:0] WR_MASK  = 12'hD8F;
  localparam logic [11:0] CMP_MASK = 12'h070;
  localparam logic [7:0]  TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state, state_nx;
  logic [1:0]       err_q, err_nx;
  logic [11:0]      op_q;
  logic             src_q, dst_q, cmp_q;
  logic [7:0]       imm_q, tmo_q;
  logic [CNT_W-1:0] ret_q;
  logic             is_cmp, is_mem, is_wr, in_alu;

  assign is_cmp = |(op_q & CMP_MASK);
  assign is_mem = op_q[OP_LD] | op_q[OP_STR];
  assign is_wr  = |(op_q & WR_MASK);
  assign in_alu = state inside {EXEC, MEM, WB};

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    err_nx   = err_q;
    unique case (state)
      IDLE:  state_nx = FETCH;
      FETCH: begin
        if (bus.if_ack_i) begin
          if ($onehot(bus.id_op_i)) begin
            state_nx = EXEC;
          end else begin
            state_nx = ERR;
            err_nx   = 2'd1;
          end
        end
      end
      EXEC:  state_nx = is_mem ? MEM : WB;
      MEM: begin
        // a late ack on the final allowed cycle still completes
        if (bus.mem_ack_i) begin
          state_nx = WB;
        end else if (tmo_q == TMO_LAST) begin
          state_nx = ERR;
          err_nx   = 2'd2;
        end
      end
      WB:      state_nx = FETCH;
      ERR:     state_nx = ERR;
      default: state_nx = ERR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= '0;
      op_q  <= '0;
      src_q <= 1'b0;
      dst_q <= 1'b0;
      imm_q <= '0;
      cmp_q <= 1'b0;
      tmo_q <= '0;
      ret_q <= '0;
    end else begin
      err_q <= err_nx;
      if (state == FETCH && bus.if_ack_i) begin
        op_q  <= bus.id_op_i;
        src_q <= bus.src_reg_i;
        dst_q <= bus.dst_reg_i;
        imm_q <= bus.imm_addr_const_i;
      end
      if (state == EXEC && is_cmp) cmp_q <= bus.alu_cmp_i;
      tmo_q <= (state == MEM) ? tmo_q + 8'd1 : 8'd0;
      if (state == WB) ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign bus.if_req_o = state == FETCH;
  assign bus.alu_op_o = in_alu ? {
    op_q[OP_SHFTR] | op_q[OP_SHFTL] | op_q[OP_INV] | op_q[OP_MVI],
    op_q[OP_CMPLT] | op_q[OP_CMPEQ] | op_q[OP_CMPEQI]
      | op_q[OP_INV] | op_q[OP_MVI],
    op_q[OP_ADD] | op_q[OP_ADDI] | op_q[OP_CMPEQ]
      | op_q[OP_CMPEQI] | op_q[OP_SHFTL] | op_q[OP_MVI]
  } : 3'd0;
  assign bus.alu_imm_o = in_alu
    & (op_q[OP_ADDI] | op_q[OP_CMPEQI] | op_q[OP_MVI]);
  assign bus.rf_src_o      = src_q;
  assign bus.rf_dst_o      = dst_q;
  assign bus.rf_we_o       = (state == WB) & is_wr;
  assign bus.rf_wsel_mem_o = (state == WB) & op_q[OP_LD];
  assign bus.mem_req_o     = state == MEM;
  assign bus.mem_we_o      = (state == MEM) & op_q[OP_STR];
  assign bus.mem_addr_o    = (state == MEM) ? imm_q : 8'd0;
  assign bus.cmp_flag_o    = cmp_q;
  assign bus.busy_o        = !(state inside {IDLE, ERR});
  assign bus.err_o         = err_q;
  assign bus.retired_o     = ret_q;

  logic unused_and;
  assign unused_and = op_q[OP_AND];
endmodule
